// File: rtl/button_conditioner.sv
`default_nettype none
//============================================================================
// Module      : button_conditioner
// Description : Input-conditioning stage between the raw Pmod button pins
//               and the pong core. Each of N_CH active-low mechanical
//               buttons is inverted, passed through a two-flop synchroniser
//               into the pixel-clock domain, and debounced on its own.
//               The block presents clean active-high levels plus one-cycle
//               press / release pulses.
//
// Parameters  : N_CH      - number of independent button channels
//               DEBOUNCE  - consecutive differing samples needed before the
//                           debounced level changes (must be >= 2)
//               CNT_W     - width of each channel's debounce counter
//
// Ports       : clk           in  1     pixel clock, rising-edge active
//               rst_n         in  1     asynchronous active-low reset
//               pins_n        in  N_CH  raw button pins, 0 = pressed,
//                                       asynchronous to clk
//               level         out N_CH  debounced state, 1 = pressed
//               press         out N_CH  one-cycle pulse on level 0->1
//               release_pulse out N_CH  one-cycle pulse on level 1->0
//                                       ("release" is a reserved word in
//                                       SystemVerilog, hence the suffix)
//
// Revision    : 1.0 - initial release
//============================================================================
module button_conditioner #(
    parameter int N_CH     = 8,
    parameter int DEBOUNCE = 262144,
    parameter int CNT_W    = $clog2(DEBOUNCE)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] pins_n,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse
);

    // Terminal count: the edge on which the counter holds this value while
    // the synchronised input still differs from the level is the edge on
    // which the level flips. DEBOUNCE-1 always fits in $clog2(DEBOUNCE) bits.
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    //------------------------------------------------------------------------
    // One fully independent conditioner per channel. All state is local to
    // the generate scope so that every register has exactly one driver.
    //------------------------------------------------------------------------
    for (genvar i = 0; i < N_CH; i++) begin : g_ch

        logic             r_s1;       // first synchroniser stage (inverted pin)
        logic             r_s2;       // second stage, only stage used downstream
        logic             r_level;    // debounced level
        logic [CNT_W-1:0] r_cnt;      // consecutive differing samples minus one
        logic             r_press;
        logic             r_release;

        logic             w_differs;  // synchronised input disagrees with level
        logic             w_expired;  // this edge completes the debounce run

        assign w_differs = (r_s2 != r_level);
        assign w_expired = w_differs && (r_cnt == c_CNT_MAX);

        //--------------------------------------------------------------------
        // Synchroniser. The inversion sits in front of the first flop so the
        // whole downstream path is active-high; it adds no logic after s2.
        //--------------------------------------------------------------------
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1 <= 1'b0;
                r_s2 <= 1'b0;
            end else begin
                r_s1 <= ~pins_n[i];
                r_s2 <= r_s1;
            end
        end

        //--------------------------------------------------------------------
        // Debounce counter. Any sample that agrees with the current level
        // wipes the count, so a bounce costs the whole run (no partial
        // credit). The counter is reset on the flip itself and therefore
        // never wraps.
        //--------------------------------------------------------------------
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (!w_differs || w_expired) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end

        //--------------------------------------------------------------------
        // Level and edge pulses. The pulses are registered alongside the
        // level so they coincide with the level change and last exactly one
        // cycle; the new level is r_s2, which selects press vs release, so
        // the two can never be high together.
        //--------------------------------------------------------------------
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                if (w_expired) begin
                    r_level   <= r_s2;
                    r_press   <= r_s2;
                    r_release <= ~r_s2;
                end
            end
        end

        assign level[i]         = r_level;
        assign press[i]         = r_press;
        assign release_pulse[i] = r_release;

`ifndef SYNTHESIS
        // A pulse always accompanies the level it announces.
        a_press_level : assert property (
            @(posedge clk) disable iff (!rst_n) r_press |-> r_level);
        a_release_level : assert property (
            @(posedge clk) disable iff (!rst_n) r_release |-> !r_level);
        a_exclusive : assert property (
            @(posedge clk) disable iff (!rst_n) !(r_press && r_release));
`endif

    end : g_ch

endmodule : button_conditioner
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
//============================================================================
// Module      : tb_button_conditioner
// Description : Directed, self-checking bench for button_conditioner with
//               DEBOUNCE=4, N_CH=8. A behavioural model derives the expected
//               outputs from the pin history: a channel flips on an edge when
//               the synchronised input seen on each of the last DEBOUNCE
//               edges (all since the previous flip or reset) differed from
//               the current level. Literal checks pin the model to
//               hand-computed timings.
// Revision    : 1.0 - initial release
//============================================================================
module tb_button_conditioner;

    localparam int N = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] pins_n = '1;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] release_pulse;

    int tests = 0;
    int fails = 0;

    button_conditioner #(
        .N_CH     (N),
        .DEBOUNCE (D)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pins_n        (pins_n),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    //------------------------------------------------------------------------
    // Behavioural model and per-cycle compare
    //------------------------------------------------------------------------
    logic [N-1:0] pin_hist[$];     // ~pins_n as sampled at edge k (0 in reset)
    int           edge_no   = 0;
    int           rst_edge  = 0;   // first edge after the latest reset
    int           start[N];        // earliest edge counting toward a flip
    logic [N-1:0] m_level   = '0;
    logic [N-1:0] m_press   = '0;
    logic [N-1:0] m_release = '0;

    // Synchronised value the design sees just before edge j: the pin taken
    // two edges earlier, or 0 while the synchroniser is still refilling.
    function automatic logic [N-1:0] s2_at(int j);
        if (j - rst_edge >= 2) return pin_hist[j-2];
        return '0;
    endfunction

    initial for (int i = 0; i < N; i++) start[i] = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            pin_hist.push_back('0);
            m_level   = '0;
            m_press   = '0;
            m_release = '0;
            rst_edge  = edge_no + 1;
            for (int i = 0; i < N; i++) start[i] = edge_no + 1;
        end else begin
            pin_hist.push_back(~pins_n);
            m_press   = '0;
            m_release = '0;
            for (int i = 0; i < N; i++) begin
                bit flip;
                flip = 1'b1;
                for (int j = edge_no - D + 1; j <= edge_no; j++) begin
                    if (j < start[i]) flip = 1'b0;
                    else if (s2_at(j)[i] == m_level[i]) flip = 1'b0;
                end
                if (flip) begin
                    m_level[i] = ~m_level[i];
                    if (m_level[i]) m_press[i] = 1'b1;
                    else            m_release[i] = 1'b1;
                    start[i] = edge_no + 1;
                end
            end
        end
        edge_no++;
        #1;
        tests++;
        if (level !== m_level || press !== m_press || release_pulse !== m_release) begin
            fails++;
            $display("FAIL model edge %0d: level/press/release got %h/%h/%h exp %h/%h/%h",
                     edge_no - 1, level, press, release_pulse, m_level, m_press, m_release);
        end
    end

    //------------------------------------------------------------------------
    // Literal checks and stimulus
    //------------------------------------------------------------------------
    task automatic chk(string name, logic [N-1:0] got, logic [N-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h exp %h", name, got, exp);
        end
    endtask

    task automatic steps(int n);
        repeat (n) @(negedge clk);
    endtask

    int press4_count;
    int level4_low;

    initial begin
        // 1. Reset with every button held.
        pins_n = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_level", level, 8'h00);
        chk("reset_press", press, 8'h00);
        chk("reset_release", release_pulse, 8'h00);
        steps(3);
        rst_n = 1'b1;
        steps(5);
        chk("post_reset_no_early_press", press, 8'h00);
        steps(1);
        chk("post_reset_press", press, 8'hFF);
        chk("post_reset_level", level, 8'hFF);
        steps(1);
        chk("post_reset_press_drop", press, 8'h00);

        // Let everything go.
        pins_n = 8'hFF;
        steps(6);
        chk("all_release_pulse", release_pulse, 8'hFF);
        chk("all_release_level", level, 8'h00);
        steps(1);
        chk("all_release_drop", release_pulse, 8'h00);

        // 2. Clean press / release on channel 0.
        pins_n = 8'hFE;
        steps(5);
        chk("ch0_press_early", press, 8'h00);
        steps(1);
        chk("ch0_press", press, 8'h01);
        chk("ch0_level", level, 8'h01);
        steps(1);
        chk("ch0_press_drop", press, 8'h00);
        pins_n = 8'hFF;
        steps(6);
        chk("ch0_release", release_pulse, 8'h01);
        chk("ch0_level_low", level, 8'h00);
        steps(2);

        // 3. Bounce rejection on channel 2: 3 low, 1 high, 3 low, high.
        pins_n = 8'hFB; steps(3);
        pins_n = 8'hFF; steps(1);
        pins_n = 8'hFB; steps(3);
        pins_n = 8'hFF; steps(8);
        chk("ch2_bounce_level", level, 8'h00);
        pins_n = 8'hFB;
        steps(6);
        chk("ch2_press", press, 8'h04);
        chk("ch2_level", level, 8'h04);

        // 4. Channels 1 and 5 together, channel 3 bouncing every 2 cycles.
        for (int j = 0; j < 10; j++) begin
            pins_n = ~(8'h26 | ((((j / 2) % 2) == 1) ? 8'h08 : 8'h00));
            steps(1);
            if (j == 5) begin
                chk("indep_press", press, 8'h22);
                chk("indep_level", level, 8'h26);
            end
        end
        chk("indep_ch3_untouched", level, 8'h26);
        pins_n = 8'hFF;
        steps(8);
        chk("indep_all_released", level, 8'h00);

        // 5. Reset in the middle of a channel-7 count.
        pins_n = 8'h7F;
        steps(3);
        rst_n = 1'b0;
        #1;
        chk("midcount_reset_level", level, 8'h00);
        steps(1);
        rst_n = 1'b1;
        steps(5);
        chk("midcount_no_early_press", press, 8'h00);
        steps(1);
        chk("midcount_press", press, 8'h80);
        chk("midcount_level", level, 8'h80);

        // 6. Long hold on channel 4 (channel 7 stays held).
        pins_n = 8'h6F;
        steps(6);
        chk("hold_press", press, 8'h10);
        press4_count = 0;
        level4_low   = 0;
        for (int j = 0; j < 1000; j++) begin
            steps(1);
            if (press[4])  press4_count++;
            if (!level[4]) level4_low++;
        end
        tests++;
        if (press4_count != 0) begin
            fails++;
            $display("FAIL hold_extra_press: got %0d exp 0", press4_count);
        end
        tests++;
        if (level4_low != 0) begin
            fails++;
            $display("FAIL hold_level_drop: got %0d exp 0", level4_low);
        end

        pins_n = 8'hFF;
        steps(8);
        chk("final_level", level, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_button_conditioner
`default_nettype wire
